// File: rtl/irq_aggregator_pkg.sv
// irq_aggregator_pkg: shared constants and types for the interrupt aggregator.
//   ADDR_*  : register word addresses on the Avalon-MM slave port
//   ID_W    : width of the encoded source ID
//   MAX_IRQ : largest supported number of interrupt sources
//   word_t  : 16-bit register word
package irq_aggregator_pkg;

    localparam int unsigned ID_W    = 4;
    localparam int unsigned MAX_IRQ = 16;

    localparam logic [2:0] ADDR_PENDING  = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd2;
    localparam logic [2:0] ADDR_ACTIVE   = 3'd3;
    localparam logic [2:0] ADDR_RAW      = 3'd4;
    localparam logic [2:0] ADDR_COUNT    = 3'd5;

    typedef logic [15:0] word_t;

endpackage

// File: rtl/irq_aggregator_if.sv
// irq_aggregator_if: Avalon-MM register bus of the interrupt aggregator.
//   address    : register word address
//   chipselect : slave select
//   write_n    : active-low write strobe, qualified by chipselect
//   writedata  : write data
//   readdata   : registered read data (one-cycle latency)
// Modports: master (CPU side), slave (aggregator side).
interface irq_aggregator_if;
    import irq_aggregator_pkg::*;

    logic [2:0] address;
    logic       chipselect;
    logic       write_n;
    word_t      writedata;
    word_t      readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/irq_aggregator_prio_enc.sv
// irq_aggregator_prio_enc: combinational lowest-index-first priority encoder.
//   req : request vector, NUM_IRQ wide
//   id  : index of the lowest set bit (0 when none)
//   any : at least one request set
module irq_aggregator_prio_enc
    import irq_aggregator_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0] req,
    output logic [ID_W-1:0]    id,
    output logic               any
);

    always_comb begin
        id  = '0;
        any = 1'b0;
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (req[i] && !any) begin
                id  = ID_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_aggregator.sv
// irq_aggregator: Avalon-MM slave interrupt controller.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : register interface (irq_aggregator_if.slave)
//   irq_in     : NUM_IRQ source interrupts, bit 0 = interval timer
//   irq        : registered CPU interrupt request
//   irq_id     : registered ID of the highest-priority active source
// Registers: 0 PENDING (W1C on edge bits), 1 MASK, 2 EDGE_SEL, 3 ACTIVE
// (write = acknowledge), 4 RAW, 5 COUNT, 6-7 read 0.
// Build option IRQ_AGGREGATOR_COUNT_EN adds the acknowledge counter at COUNT.
module irq_aggregator
    import irq_aggregator_pkg::*;
#(
    parameter int unsigned NUM_IRQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    irq_aggregator_if.slave    bus,
    input  logic [NUM_IRQ-1:0] irq_in,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id
);

    logic [NUM_IRQ-1:0] irq_in_q;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] edge_sel;
    logic               valid;

    logic [NUM_IRQ-1:0] pending_nxt;
    logic [NUM_IRQ-1:0] clr_vec;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] active;
    logic [ID_W-1:0]    enc_id;
    logic               enc_any;
    logic               wr;
    logic               ack;
    word_t              rd_mux;

`ifdef IRQ_AGGREGATOR_COUNT_EN
    word_t              count;
`endif

    assign wr     = bus.chipselect && !bus.write_n;
    // Acknowledge is judged against the registered valid/irq_id seen by software.
    assign ack    = wr && (bus.address == ADDR_ACTIVE) && valid;
    assign rise   = irq_in & ~irq_in_q;
    assign active = pending & mask;

    irq_aggregator_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
        .req (active),
        .id  (enc_id),
        .any (enc_any)
    );

    // Edge bits: a new rising edge wins over any same-cycle clear.
    // Level bits simply follow the input.
    always_comb begin
        clr_vec = '0;
        if (wr && (bus.address == ADDR_PENDING))
            clr_vec = bus.writedata[NUM_IRQ-1:0];
        for (int unsigned i = 0; i < NUM_IRQ; i++) begin
            if (ack && (irq_id == ID_W'(i)))
                clr_vec[i] = 1'b1;
        end
        pending_nxt = (edge_sel & (rise | (pending & ~clr_vec))) |
                      (~edge_sel & irq_in);
    end

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_PENDING:  rd_mux = word_t'(pending);
            ADDR_MASK:     rd_mux = word_t'(mask);
            ADDR_EDGE_SEL: rd_mux = word_t'(edge_sel);
            ADDR_ACTIVE:   rd_mux = {valid, 11'b0, irq_id};
            ADDR_RAW:      rd_mux = word_t'(irq_in_q);
`ifdef IRQ_AGGREGATOR_COUNT_EN
            ADDR_COUNT:    rd_mux = count;
`endif
            default:       rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_in_q     <= '0;
            pending      <= '0;
            mask         <= '0;
            edge_sel     <= '0;
            valid        <= 1'b0;
            irq          <= 1'b0;
            irq_id       <= '0;
            bus.readdata <= '0;
        end else begin
            irq_in_q     <= irq_in;
            pending      <= pending_nxt;
            if (wr && (bus.address == ADDR_MASK))
                mask <= bus.writedata[NUM_IRQ-1:0];
            if (wr && (bus.address == ADDR_EDGE_SEL))
                edge_sel <= bus.writedata[NUM_IRQ-1:0];
            valid        <= enc_any;
            irq          <= enc_any;
            irq_id       <= enc_id;
            bus.readdata <= rd_mux;
        end
    end

`ifdef IRQ_AGGREGATOR_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (wr && (bus.address == ADDR_COUNT))
            count <= '0;
        else if (ack)
            count <= count + 16'd1;
    end
`endif

endmodule

// File: doc/irq_aggregator.md
# irq_aggregator

Avalon-MM slave interrupt controller sitting directly downstream of the interval timer and peer peripherals in the SoC. It samples up to 16 interrupt inputs (the timer's `irq` on input 0), latches them per-source as level or rising-edge events, masks and prioritises them, and drives a single registered `irq` with the winning source ID to the CPU. Software reads pending status and acknowledges through the same 16-bit, one-cycle-read-latency register interface style as the timer.

## Interface
- `NUM_IRQ`, 4: number of interrupt sources, 1..16
- `clk` input 1: system clock; single clock domain
- `reset` input 1: synchronous, active-high reset
- `address` input 3: register word address
- `chipselect` input 1: slave select
- `write_n` input 1: active-low write strobe, qualified by `chipselect`
- `writedata` input 16: write data
- `readdata` output 16: registered read data
- `irq_in` input NUM_IRQ: source interrupts, same clock domain; bit 0 = timer
- `irq` output 1: registered CPU interrupt request
- `irq_id` output 4: registered ID of the highest-priority active source

## Operation
- Write strobe: `chipselect && !write_n`. Bits at or above NUM_IRQ read 0; writes to them are ignored.
- Register map:
  - 0 PENDING: read pending vector. Write: W1C on edge-mode bits.
  - 1 MASK: read/write enable vector.
  - 2 EDGE_SEL: read/write; 1 = rising-edge latched, 0 = level.
  - 3 ACTIVE: read `{valid, 11'b0, id[3:0]}`. Any write is an acknowledge.
  - 4 RAW: read `irq_in_q`, the input register.
  - 5 COUNT: see Configuration.
  - 6–7: read 0.
- `irq_in_q <= irq_in` every cycle.
- Level source: `pending[i] <= irq_in[i]`. W1C and acknowledge have no effect.
- Edge source: `pending[i]` is set when `irq_in[i] && !irq_in_q[i]`. It clears on W1C, or on an acknowledge while `valid && id == i`.
- Set beats clear when a new edge coincides with W1C or acknowledge in the same cycle; the event is never lost.
- Changing EDGE_SEL takes effect from the next cycle and does not clear `pending`.
- `active = pending & mask`. Priority: lowest index wins (priority encoder).
- Registered each cycle:
  - `irq <= |active`
  - `irq_id <= encoded index` (0 when none)
  - `valid <= |active`
- `readdata <= mux(address)` every cycle, not gated by `chipselect`.

## Timing
- Reset values:
  - `readdata` = 0, `irq` = 0, `irq_id` = 0, `valid` = 0
  - `pending` = 0, `mask` = 0, `EDGE_SEL` = 0, `irq_in_q` = 0, COUNT = 0
- Reset mid-operation: all state returns to reset values on the next edge; in-flight events are discarded.
- Input to output: `irq_in` high before edge E0 → `pending` set at E0 → `irq`/`irq_id` valid after E1. Latency is 2 cycles.
- Register write to `irq`: a write to MASK, PENDING or ACTIVE at edge E0 is reflected on `irq` after E1.
- Read latency: 1 cycle; `readdata` reflects register state before the edge that captures it.
- A held-high edge input produces exactly one event until it deasserts for at least one cycle.
- Acknowledge uses the registered `irq_id`/`valid` current at the write edge. Acknowledge with `valid` = 0 is a no-op.

## Configuration
- Macro: `IRQ_AGGREGATOR_COUNT_EN`.
- Defined:
  - COUNT (address 5) is a 16-bit counter that increments on each acknowledge with `valid` = 1.
  - It wraps 0xFFFF → 0x0000.
  - Any write to address 5 clears it; clear beats a same-cycle increment (result 0).
- Undefined: no counter logic; address 5 reads 0 and writes are ignored.

## Structure
- Package `irq_aggregator_pkg`:
  - address constants `ADDR_PENDING` .. `ADDR_COUNT`
  - `ID_W = 4`, `MAX_IRQ = 16`
  - a typedef for the 16-bit register word
- Sub-module `irq_aggregator_prio_enc`: combinational lowest-index-first encoder, NUM_IRQ-wide input, outputs `id[3:0]` and `any`.
- All state lives in the top module.

## Test plan
- Level timer: reset, MASK = 0x0001, drive `irq_in[0]` = 1 → `irq` = 1, `irq_id` = 0 two cycles later. Drop `irq_in[0]` → `irq` = 0 two cycles later. A W1C write to PENDING has no effect while the input is high.
- Edge priority:
  - EDGE_SEL = 0x000F, MASK = 0x000F; pulse `irq_in[2]` and `irq_in[1]` together → ACTIVE reads 0x8001.
  - Acknowledge → ACTIVE reads 0x8002.
  - Acknowledge → `irq` = 0, ACTIVE reads 0x0000.
- Set beats clear: edge on `irq_in[3]` in the same cycle as a W1C 0x0008 → PENDING reads 0x0008.
- Masking: pending 0x0004 with MASK = 0 → `irq` = 0. Write MASK = 0x0004 → `irq` = 1 after 2 cycles.
- Counter (macro defined): with COUNT preloaded at 0xFFFF (after 65535 valid acknowledges), one more valid acknowledge → COUNT = 0x0000. Write to address 5 together with a valid acknowledge → COUNT = 0. With the macro undefined, address 5 reads 0.
- Reset mid-operation: assert `reset` for 1 cycle while `irq` = 1 → `irq`, `readdata`, `pending` and `mask` all 0 on the next cycle.
